// File: rtl/ppm_pkg.sv
// ppm_pkg: types and constants shared by the 1-of-4 PPM receive path.
//   state_t : frame sequencer states
//   ERR_*   : abort reason codes reported on err_code
package ppm_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      END   = 2'd2,
      FLUSH = 2'd3
   } state_t;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_MULTI   = 2'd1;
   localparam logic [1:0] ERR_TRUNC   = 2'd2;
   localparam logic [1:0] ERR_OVERRUN = 2'd3;

endpackage

// File: rtl/ppm_slot_timer.sv
// ppm_slot_timer: tick/slot counters for one PPM symbol (4 slots).
//   clk, rst_n   : system clock, async active-low reset
//   clr          : restart at tick 0 / slot 0 (start of frame)
//   en           : advance one tick (a clk16 strobe while receiving)
//   slot         : current slot index 0..3
//   sample_stb   : this strobe is the mid-slot sampling point
//   sym_end_stb  : this strobe is the last tick of slot 3
module ppm_slot_timer import ppm_pkg::*; #(
   parameter int SLOT_TICKS = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       en,
   output logic [1:0] slot,
   output logic       sample_stb,
   output logic       sym_end_stb
);

   localparam int            TW     = $clog2(SLOT_TICKS);
   localparam logic [TW-1:0] T_HALF = TW'(SLOT_TICKS / 2);
   localparam logic [TW-1:0] T_LAST = TW'(SLOT_TICKS - 1);

   logic [TW-1:0] tick;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick <= '0;
         slot <= '0;
      end else if (clr) begin
         tick <= '0;
         slot <= '0;
      end else if (en) begin
         if (tick == T_LAST) begin
            tick <= '0;
            slot <= slot + 2'd1;
         end else begin
            tick <= tick + TW'(1);
         end
      end
   end

   // Strobes are qualified with en so they fire for exactly one clk.
   assign sample_stb  = en && (tick == T_HALF);
   assign sym_end_stb = en && (tick == T_LAST) && (slot == 2'd3);

endmodule

// File: rtl/ppm_frame_ctrl.sv
// ppm_frame_ctrl: receive-side PPM frame sequencer.
//   clk, rst_n        : system clock, async active-low reset
//   clk16             : 16x bit-rate enable strobe (one clk wide)
//   rx_en             : receiver enable, low forces IDLE
//   din               : raw PPM line, low = pulse (synchronized here)
//   sof_rcv / eof_rcv : start-of-frame in / end-of-frame out to SOF detector
//   data_out, data_valid, data_ready : byte stream handshake
//   byte_cnt          : bytes completed in current frame
//   busy, frame_done, frame_err, err_code : frame status
module ppm_frame_ctrl import ppm_pkg::*; #(
   parameter int SLOT_TICKS = 8,
   parameter int MAX_BYTES  = 32,
   parameter int CW         = 6
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clk16,
   input  logic          rx_en,
   input  logic          din,
   input  logic          sof_rcv,
   output logic          eof_rcv,
   output logic [7:0]    data_out,
   output logic          data_valid,
   input  logic          data_ready,
   output logic [CW-1:0] byte_cnt,
   output logic          busy,
   output logic          frame_done,
   output logic          frame_err,
   output logic [1:0]    err_code
);

   localparam logic [CW-1:0] MAX_B = CW'(MAX_BYTES);

   // Idle line is high, so the synchronizer resets to "no pulse".
   logic [1:0] din_s;
   logic       din_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) din_s <= 2'b11;
      else        din_s <= {din_s[0], din};
   end
   assign din_q = din_s[1];

   state_t     state;
   logic       pulse_seen;
   logic [1:0] pulse_idx;
   logic [1:0] sym_cnt;
   logic [7:0] shreg;
   logic [7:0] byte_next;
   logic [1:0] slot;
   logic       sample_stb, sym_end_stb, tmr_clr, tmr_en;

   assign tmr_clr = (state == IDLE) && clk16 && sof_rcv && rx_en;
   assign tmr_en  = (state == RECV) && clk16 && rx_en;

   ppm_slot_timer #(.SLOT_TICKS(SLOT_TICKS)) u_timer (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr         (tmr_clr),
      .en          (tmr_en),
      .slot        (slot),
      .sample_stb  (sample_stb),
      .sym_end_stb (sym_end_stb)
   );

   // Symbols enter at the top and shift right, so after four symbols the
   // first one sits in bits [1:0].
   assign byte_next = {pulse_idx, shreg[7:2]};
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         pulse_seen <= 1'b0;
         pulse_idx  <= '0;
         sym_cnt    <= '0;
         shreg      <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         byte_cnt   <= '0;
         eof_rcv    <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         err_code   <= ERR_NONE;
      end else begin
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         // Handshake runs every clk regardless of strobe or state; a byte
         // load below overrides the clear.
         if (data_valid && data_ready) data_valid <= 1'b0;

         if (!rx_en) begin
            state <= IDLE;
            // Leaving a frame: tell the SOF detector for one strobe.
            if (state != IDLE) eof_rcv <= 1'b1;
            else if (clk16)    eof_rcv <= 1'b0;
         end else begin
            case (state)
               IDLE: if (clk16) begin
                  eof_rcv <= 1'b0;
                  if (sof_rcv) begin
                     state      <= RECV;
                     pulse_seen <= 1'b0;
                     sym_cnt    <= '0;
                     byte_cnt   <= '0;
                     err_code   <= ERR_NONE;
                  end
               end
               RECV: begin
                  if (sample_stb && !din_q) begin
                     if (pulse_seen) begin
                        state     <= END;
                        frame_err <= 1'b1;
                        err_code  <= ERR_MULTI;
                     end else begin
                        pulse_seen <= 1'b1;
                        pulse_idx  <= slot;
                     end
                  end
                  if (sym_end_stb) begin
                     if (pulse_seen) begin
                        shreg      <= byte_next;
                        sym_cnt    <= sym_cnt + 2'd1;
                        pulse_seen <= 1'b0;
                        if (sym_cnt == 2'd3) begin
                           if ((data_valid && !data_ready) || byte_cnt == MAX_B) begin
                              state     <= END;
                              frame_err <= 1'b1;
                              err_code  <= ERR_OVERRUN;
                           end else begin
                              data_out   <= byte_next;
                              data_valid <= 1'b1;
                              byte_cnt   <= byte_cnt + CW'(1);
                           end
                        end
                     end else if (sym_cnt == 2'd0 && byte_cnt != '0) begin
                        state      <= END;
                        frame_done <= 1'b1;
                     end else begin
                        state     <= END;
                        frame_err <= 1'b1;
                        err_code  <= ERR_TRUNC;
                     end
                  end
               end
               END: begin
                  state   <= FLUSH;
                  eof_rcv <= 1'b1;
               end
               FLUSH: if (clk16) begin
                  state   <= IDLE;
                  eof_rcv <= 1'b0;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ppm_frame_ctrl.sv
// tb_ppm_frame_ctrl: directed frames against a symbol-level model of the
// PPM frame sequencer, compared every clk, plus literal frame-end checks.
module tb_ppm_frame_ctrl;

   localparam int ST  = 8;
   localparam int MB  = 32;
   localparam int CW  = 6;
   localparam int DIV = 4;          // clk cycles per clk16 strobe
   localparam int SYM = 4 * ST;     // strobes per symbol

   logic          clk = 0, rst_n = 0, clk16 = 0, rx_en = 0, din = 1;
   logic          sof_rcv = 0, data_ready = 0;
   logic          eof_rcv, data_valid, busy, frame_done, frame_err;
   logic [7:0]    data_out;
   logic [CW-1:0] byte_cnt;
   logic [1:0]    err_code;

   always #5 clk = ~clk;

   ppm_frame_ctrl #(.SLOT_TICKS(ST), .MAX_BYTES(MB), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n), .clk16(clk16), .rx_en(rx_en), .din(din),
      .sof_rcv(sof_rcv), .eof_rcv(eof_rcv), .data_out(data_out),
      .data_valid(data_valid), .data_ready(data_ready), .byte_cnt(byte_cnt),
      .busy(busy), .frame_done(frame_done), .frame_err(frame_err),
      .err_code(err_code)
   );

   int checks = 0, errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- frame plan and line driver ----------------
   logic [3:0] plan [16];           // per symbol: mask of slots carrying a pulse
   int         plan_len = 0;
   bit         go = 0, drv_on = 0;
   int         div_cnt = 0, dk = 0, eof_strobes = 0;

   always @(negedge clk) begin
      div_cnt = (div_cnt == DIV - 1) ? 0 : div_cnt + 1;
      clk16   = (div_cnt == 0);
      if (clk16) begin
         sof_rcv = 1'b0;
         if (go) begin
            go = 0; sof_rcv = 1'b1; dk = 0; drv_on = 1;
         end else if (drv_on) begin
            dk++;
         end
         // Line level for the next strobe (strobe dk+1 of the frame).
         din = 1'b1;
         if (drv_on && (dk / SYM) < plan_len && plan[dk / SYM][(dk / ST) % 4])
            din = 1'b0;
         if (eof_rcv) eof_strobes++;
      end
   end

   // ---------------- behavioural model ----------------
   // Works in strobes counted from the SOF strobe: strobe k (k>=1) lies in
   // symbol (k-1)/SYM, slot ((k-1)/ST)%4; mid-slot samples, symbol closes
   // on k % SYM == 0.
   int         m_ph = 0, mk = 0, nsym = 0, pos = 0, m_bc = 0, m_code = 0;
   int         ms = 0, mj = 0, mt = 0;
   bit         seen = 0, m_dv = 0, m_done = 0, m_ferr = 0, m_eof = 0, dv_old = 0;
   logic [7:0] m_dout = 0, acc = 0;
   logic [7:0] acc_q [$];

   task automatic m_abort(input int c);
      m_ph = 2; m_ferr = 1; m_code = c;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ph = 0; m_dv = 0; m_dout = 0; m_bc = 0; m_code = 0;
         m_done = 0; m_ferr = 0; m_eof = 0; seen = 0; nsym = 0;
      end else begin
         dv_old = m_dv;
         if (m_dv && data_ready) begin acc_q.push_back(m_dout); m_dv = 0; end
         m_done = 0; m_ferr = 0;
         if (!rx_en) begin
            if (m_ph != 0) m_eof = 1;
            else if (clk16) m_eof = 0;
            m_ph = 0;
         end else begin
            case (m_ph)
               0: if (clk16) begin
                  m_eof = 0;
                  if (sof_rcv) begin
                     m_ph = 1; mk = 0; m_bc = 0; m_code = 0; nsym = 0; seen = 0;
                  end
               end
               1: if (clk16) begin
                  mk++;
                  ms = (mk - 1) / SYM; mj = ((mk - 1) / ST) % 4; mt = (mk - 1) % ST;
                  if (mt == ST / 2 && ms < plan_len && plan[ms][mj]) begin
                     if (seen) m_abort(1);
                     else begin seen = 1; pos = mj; end
                  end
                  if (m_ph == 1 && mk % SYM == 0) begin
                     if (seen) begin
                        acc[2*nsym +: 2] = 2'(pos);
                        seen = 0; nsym++;
                        if (nsym == 4) begin
                           nsym = 0;
                           if ((dv_old && !data_ready) || m_bc == MB) m_abort(3);
                           else begin m_dv = 1; m_dout = acc; m_bc++; end
                        end
                     end else if (nsym == 0 && m_bc >= 1) begin
                        m_ph = 2; m_done = 1;
                     end else begin
                        m_abort(2);
                     end
                  end
               end
               2: begin m_ph = 3; m_eof = 1; end
               default: if (clk16) begin m_ph = 0; m_eof = 0; end
            endcase
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   int n_done = 0, n_err = 0;
   always @(negedge clk) begin
      chk("data_valid", 32'(data_valid), 32'(m_dv));
      chk("data_out",   32'(data_out),   32'(m_dout));
      chk("byte_cnt",   32'(byte_cnt),   32'(m_bc));
      chk("busy",       32'(busy),       32'(m_ph != 0));
      chk("frame_done", 32'(frame_done), 32'(m_done));
      chk("frame_err",  32'(frame_err),  32'(m_ferr));
      chk("err_code",   32'(err_code),   32'(m_code));
      chk("eof_rcv",    32'(eof_rcv),    32'(m_eof));
      if (frame_done) n_done++;
      if (frame_err)  n_err++;
   end

   // ---------------- stimulus ----------------
   task automatic put(input int idx, input int v);
      plan[idx] = 4'(1 << v);
   endtask

   task automatic wait_busy(input logic v, input int budget);
      int n = 0;
      while (busy !== v && n < budget) begin @(negedge clk); n++; end
      chk("wait_busy", 32'(busy), 32'(v));
   endtask

   task automatic start_frame();
      n_done = 0; n_err = 0; eof_strobes = 0; acc_q.delete();
      go = 1;
      wait_busy(1'b1, 40);
   endtask

   task automatic run_frame();
      start_frame();
      wait_busy(1'b0, 20 * SYM * DIV);
      repeat (2) @(negedge clk);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_data_out"},   32'(data_out),   32'h0);
      chk({tag, "_data_valid"}, 32'(data_valid), 32'h0);
      chk({tag, "_byte_cnt"},   32'(byte_cnt),   32'h0);
      chk({tag, "_busy"},       32'(busy),       32'h0);
      chk({tag, "_eof"},        32'(eof_rcv),    32'h0);
      chk({tag, "_err_code"},   32'(err_code),   32'h0);
   endtask

   initial begin
      repeat (4) @(negedge clk);
      check_zero("reset");
      #1 rst_n = 1; rx_en = 1;
      repeat (8) @(negedge clk);

      // Single byte 1,0,3,2 -> 0xB1, left pending (data_ready low).
      put(0, 1); put(1, 0); put(2, 3); put(3, 2); plan_len = 4;
      run_frame();
      chk("t1_data_out",    32'(data_out),   32'hB1);
      chk("t1_valid",       32'(data_valid), 32'h1);
      chk("t1_byte_cnt",    32'(byte_cnt),   32'h1);
      chk("t1_done_pulses", 32'(n_done),     32'h1);
      chk("t1_err_pulses",  32'(n_err),      32'h0);
      chk("t1_eof_strobes", 32'(eof_strobes), 32'h1);

      // Two bytes with data_ready high: 0x00 then 0xFF.
      data_ready = 1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 4; i++) begin put(i, 0); put(i + 4, 3); end
      plan_len = 8;
      run_frame();
      chk("t2_nbytes",      32'(acc_q.size()), 32'h2);
      if (acc_q.size() == 2) begin
         chk("t2_byte0", 32'(acc_q[0]), 32'h00);
         chk("t2_byte1", 32'(acc_q[1]), 32'hFF);
      end
      chk("t2_done_pulses", 32'(n_done),   32'h1);
      chk("t2_err_code",    32'(err_code), 32'h0);
      chk("t2_byte_cnt",    32'(byte_cnt), 32'h2);

      // Pulses in slots 0 and 2 of one symbol.
      plan[0] = 4'b0101; plan_len = 1;
      run_frame();
      chk("t3_err_pulses",  32'(n_err),    32'h1);
      chk("t3_err_code",    32'(err_code), 32'h1);
      chk("t3_busy",        32'(busy),     32'h0);

      // EOF after two symbols, then an empty frame.
      put(0, 1); put(1, 2); plan_len = 2;
      run_frame();
      chk("t4a_err_code",   32'(err_code), 32'h2);
      chk("t4a_err_pulses", 32'(n_err),    32'h1);
      plan_len = 0;
      run_frame();
      chk("t4b_err_code",   32'(err_code), 32'h2);
      chk("t4b_done",       32'(n_done),   32'h0);

      // Overrun: data_ready low across two bytes; first byte 2,1,0,3 = 0xC6.
      data_ready = 0;
      put(0, 2); put(1, 1); put(2, 0); put(3, 3);
      for (int i = 4; i < 8; i++) put(i, 1);
      plan_len = 8;
      run_frame();
      chk("t5_err_code",    32'(err_code),   32'h3);
      chk("t5_data_out",    32'(data_out),   32'hC6);
      chk("t5_valid",       32'(data_valid), 32'h1);
      chk("t5_byte_cnt",    32'(byte_cnt),   32'h1);
      data_ready = 1;
      repeat (4) @(negedge clk);

      // rx_en dropped mid-byte.
      for (int i = 0; i < 8; i++) put(i, i % 4);
      plan_len = 8;
      start_frame();
      repeat (200) @(negedge clk);
      rx_en = 0;
      repeat (12) @(negedge clk);
      chk("t6_busy",        32'(busy),        32'h0);
      chk("t6_done",        32'(n_done),      32'h0);
      chk("t6_err",         32'(n_err),       32'h0);
      chk("t6_eof_strobes", 32'(eof_strobes), 32'h1);
      rx_en = 1;
      repeat (8) @(negedge clk);

      // Reset mid-frame, then a clean frame.
      start_frame();
      repeat (300) @(negedge clk);
      #1 rst_n = 0;
      repeat (3) @(negedge clk);
      check_zero("t7_inreset");
      chk("t7_done", 32'(n_done), 32'h0);
      chk("t7_err",  32'(n_err),  32'h0);
      #1 rst_n = 1;
      data_ready = 0;
      repeat (8) @(negedge clk);
      put(0, 1); put(1, 0); put(2, 3); put(3, 2); plan_len = 4;
      run_frame();
      chk("t8_data_out",    32'(data_out), 32'hB1);
      chk("t8_byte_cnt",    32'(byte_cnt), 32'h1);
      chk("t8_done_pulses", 32'(n_done),   32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
